mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (legal range 2..4).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port req_valid, input, NREQ, per-requester request, held until acknowledged.
REQ-005 SHALL have port req_addr, input, NREQ*32, byte address, requester i in bits [32i+31:32i].
REQ-006 SHALL have port req_wdata, input, NREQ*32, write data, same packing as req_addr.
REQ-007 SHALL have port req_wmask, input, NREQ*4, byte write mask; all-zero means read.
REQ-008 SHALL have port req_ack, output, NREQ, one-hot acceptance pulse.
REQ-009 SHALL have port rsp_valid, output, NREQ, one-hot read-data-valid pulse.
REQ-010 SHALL have port rsp_rdata, output, 32, read data, shared by all requesters.
REQ-011 SHALL have ports mem_addr (output, 32), mem_rstrb (output, 1), mem_wdata (output, 32), mem_wmask (output, 4) and mem_rdata (input, 32), forming the single RAM port; RAM returns read data one cycle after mem_rstrb.

Function
REQ-012 SHALL implement states IDLE, ISSUE and RESP.
REQ-013 In IDLE with any req_valid set, SHALL pick a winner, latch its index, addr, wdata and wmask into registers, and go to ISSUE; with no request, SHALL stay in IDLE.
REQ-014 In ISSUE, SHALL drive mem_addr, mem_wdata and mem_wmask from the latched command.
REQ-015 In ISSUE, SHALL assert mem_rstrb=1 only when the latched wmask is zero.
REQ-016 In ISSUE, SHALL pulse req_ack[winner] for exactly one cycle.
REQ-017 From ISSUE, SHALL go to RESP for a read and to IDLE for a write.
REQ-018 In RESP, SHALL assert rsp_valid[winner] for one cycle with rsp_rdata=mem_rdata, then go to IDLE.
REQ-019 Latency (request seen in IDLE at cycle t): ack at t+1; read data at t+2; next arbitration at t+3 for a read, t+2 for a write.
REQ-020 Outside ISSUE, SHALL hold mem_rstrb=0 and mem_wmask=0; mem_addr and mem_wdata are don't-care.
REQ-021 Command is registered, so dropping or changing req_valid or req fields after IDLE has no effect on the transaction in flight.
REQ-022 A requester still asserting req_valid in the cycle after its ack is treated as a new request.
REQ-023 rsp_rdata is don't-care when no rsp_valid bit is set; req_ack and rsp_valid SHALL never assert in the same cycle.

Reset
REQ-024 While resetn=0 at a clock edge, SHALL enter IDLE, clear req_ack, rsp_valid, mem_rstrb and mem_wmask, and set the last-grant pointer to NREQ-1.
REQ-025 Reset during ISSUE or RESP SHALL abort the transaction with no ack or rsp_valid pulse afterwards; a write already issued to RAM is not undone.

Configuration
REQ-026 With MEM_ARB_RR_EN defined, SHALL use round-robin arbitration: search starts at the last-grant index + 1 (mod NREQ), and the pointer updates on each grant.
REQ-027 Without MEM_ARB_RR_EN, SHALL use fixed priority (lowest index wins); the pointer register is absent.

Structure
REQ-028 SHALL place the state encoding, the NREQ upper bound (4) and the word/mask width constants in package mem_arb_pkg.
REQ-029 SHALL implement winner selection in sub-module mem_arb_pick: inputs are the request vector and the pointer; output is a one-hot grant; purely combinational.

Verification
REQ-030 Requester 0 writes addr 0x10, wdata 0xDEADBEEF, wmask 4'b1111; then reads 0x10 -> req_ack[0] at t+1; on the read, rsp_valid[0] at t+2 with rsp_rdata=0xDEADBEEF.
REQ-031 Requester 1 writes 0x20, wmask 4'b0100, wdata 0x00AB0000, over a word holding 0x11223344; then reads 0x20 -> rsp_rdata=0x11AB3344.
REQ-032 Both requesters read continuously with RR enabled -> acks alternate 0,1,0,1 after reset; with RR disabled, requester 0 wins every time.
REQ-033 Assert resetn=0 in RESP of a read by requester 1 -> no rsp_valid; IDLE afterwards; next simultaneous request is granted to requester 0.
REQ-034 Requester 0 changes req_addr from 0x30 to 0x40 during ISSUE -> mem_addr stays 0x30 and exactly one ack is issued.
REQ-035 Idle bus for 100 cycles -> mem_rstrb=0 and mem_wmask=0 throughout, with no ack or rsp pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants, state encoding and helpers for the memory arbiter.
package mem_arb_pkg;

    localparam int NREQ_MAX = 4;
    localparam int WORD_W   = 32;
    localparam int MASK_W   = 4;
    localparam int PTR_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-port bundle; slave is the arbiter side, master the requesters plus RAM.
interface mem_arbiter_if #(parameter int NREQ = 2);
    import mem_arb_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WORD_W-1:0] req_addr;
    logic [NREQ*WORD_W-1:0] req_wdata;
    logic [NREQ*MASK_W-1:0] req_wmask;
    logic [NREQ-1:0]        req_ack;
    logic [NREQ-1:0]        rsp_valid;
    logic [WORD_W-1:0]      rsp_rdata;

    logic [WORD_W-1:0]      mem_addr;
    logic                   mem_rstrb;
    logic [WORD_W-1:0]      mem_wdata;
    logic [MASK_W-1:0]      mem_wmask;
    logic [WORD_W-1:0]      mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wmask, mem_rdata,
        output req_ack, rsp_valid, rsp_rdata, mem_addr, mem_rstrb, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_wmask, mem_rdata,
        input  req_ack, rsp_valid, rsp_rdata, mem_addr, mem_rstrb, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: first requester found searching upward from i_ptr + 1 (mod NREQ).
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant
);

    logic [2:0] w_sum;
    logic       w_found;

    // Fixed priority is this same search with i_ptr tied to NREQ-1 by the parent.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + 3'(k + 1);
            if (w_sum >= 3'(NREQ)) w_sum = w_sum - 3'(NREQ);
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && (w_sum == 3'(j)) && i_req[j]) begin
                    o_grant[j] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// NREQ-way arbiter onto a single RAM port: IDLE -> ISSUE -> (RESP) -> IDLE.
// Define MEM_ARB_RR_EN for round-robin; default build is fixed priority (lowest index wins).
//
// state | meaning
// IDLE  | waiting for a request; winner's command latched on grant
// ISSUE | latched command on the RAM port, one-cycle ack to the winner
// RESP  | read data from RAM returned with one-cycle rsp_valid
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.slave  bus
);

    arb_state_t        r_state;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_ack;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic              r_rstrb;

    logic [NREQ-1:0]   w_grant;
    logic [PTR_W-1:0]  w_ptr;
    logic [WORD_W-1:0] w_sel_addr;
    logic [WORD_W-1:0] w_sel_wdata;
    logic [MASK_W-1:0] w_sel_wmask;

    mem_arb_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant)
    );

`ifdef MEM_ARB_RR_EN
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr <= PTR_W'(NREQ - 1);
        end else if ((r_state == ST_IDLE) && (|w_grant)) begin
            r_ptr <= onehot_to_idx(NREQ_MAX'(w_grant));
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = PTR_W'(NREQ - 1);
`endif

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wmask = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_grant[j]) begin
                w_sel_addr  = w_sel_addr  | bus.req_addr[j*WORD_W +: WORD_W];
                w_sel_wdata = w_sel_wdata | bus.req_wdata[j*WORD_W +: WORD_W];
                w_sel_wmask = w_sel_wmask | bus.req_wmask[j*MASK_W +: MASK_W];
            end
        end
    end

    // Strobes default low every cycle so ack/rsp/rstrb/wmask are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_ack       <= '0;
            r_rsp_valid <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_rstrb     <= 1'b0;
        end else begin
            r_ack       <= '0;
            r_rsp_valid <= '0;
            r_wmask     <= '0;
            r_rstrb     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_grant <= w_grant;
                        r_ack   <= w_grant;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_wmask <= w_sel_wmask;
                        r_rstrb <= (w_sel_wmask == '0);
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_rstrb) begin
                        r_rsp_valid <= r_grant;
                        r_state     <= ST_RESP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack   = r_ack;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = bus.mem_rdata;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wmask = r_wmask;
    assign bus.mem_rstrb = r_rstrb;

endmodule
